// File: rtl/snake_matrix_renderer_if.sv
// Renderer-facing bundle: snake core state in, matrix drive and status out.
interface snake_matrix_renderer_if;
  logic        Update_Req;
  logic [3:0]  Length;
  logic [7:0]  Food;
  logic [7:0]  Loc_Data;
  logic [3:0]  Loc_Idx;
  logic        Busy;
  logic        Frame_Done;
  logic [15:0] Row_Sel;
  logic [15:0] Col_Head;
  logic [15:0] Col_Body;
  logic [15:0] Col_Food;

  // Core side: publishes game state, reads the renderer status.
  modport master (
    output Update_Req, Length, Food, Loc_Data,
    input  Loc_Idx, Busy, Frame_Done, Row_Sel, Col_Head, Col_Body, Col_Food
  );

  // Renderer side.
  modport slave (
    input  Update_Req, Length, Food, Loc_Data,
    output Loc_Idx, Busy, Frame_Done, Row_Sel, Col_Head, Col_Body, Col_Food
  );
endinterface

// File: rtl/snake_matrix_renderer.sv
// Double-buffered 16x16 LED matrix renderer for the snake core. A build walks the
// location array into the back buffer; the buffers swap on the next row-0 boundary.
module snake_matrix_renderer #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input logic                    Clk,
  input logic                    Reset,
  snake_matrix_renderer_if.slave bus
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StFood, StWaitSwap} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      len_q, len_d;
  logic [7:0]      fd_q, fd_d;
  logic [3:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pending_q, pending_d;
  logic            clr_row, set_head, set_body, set_food, swap;

  logic [DivW-1:0] div_q;
  logic [3:0]      row_q;
  logic [15:0]     row_sel_q;
  logic [15:0]     col_head_q, col_body_q, col_food_q;
  logic            front_q, front_d, back;
  logic            div_wrap, row0_edge;

  // Plane buffers indexed [bank][row]; bit c of a row word is column c.
  logic [15:0]     head_q [2][16];
  logic [15:0]     body_q [2][16];
  logic [15:0]     food_q [2][16];

  assign div_wrap  = (div_q == DivW'(SCAN_DIV - 1));
  assign row0_edge = div_wrap && (row_q == 4'd15);
  assign front_d   = front_q ^ swap;
  assign back      = ~front_q;

  // Build FSM next-state and control decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    fd_d      = fd_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pending_d = pending_q | (bus.Update_Req & busy_q);
    clr_row   = 1'b0;
    set_head  = 1'b0;
    set_body  = 1'b0;
    set_food  = 1'b0;
    swap      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.Update_Req || pending_q) begin
          state_d   = StClear;
          len_d     = bus.Length;
          fd_d      = bus.Food;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          cnt_d     = 5'd0;
        end
      end
      StClear: begin
        clr_row = 1'b1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = StLoad;
          cnt_d   = 5'd0;
          idx_d   = 4'd0;
        end
      end
      StLoad: begin
        // cnt_q counts LOAD cycles; data for segment cnt_q-1 arrives this cycle.
        if (cnt_q == 5'd1) set_head = 1'b1;
        else if (cnt_q != 5'd0) set_body = 1'b1;
        if (cnt_q < {1'b0, len_q}) idx_d = idx_q + 4'd1;
        if (cnt_q == {1'b0, len_q} + 5'd1) state_d = StFood;
        else cnt_d = cnt_q + 5'd1;
      end
      StFood: begin
        set_food = 1'b1;
        state_d  = StWaitSwap;
      end
      StWaitSwap: begin
        if (row0_edge) begin
          swap    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Build FSM state and latched request registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      len_q     <= 4'd0;
      fd_q      <= 8'd0;
      idx_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      fd_q      <= fd_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  // Free-running row scanner; column words load together with Row_Sel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q      <= '0;
      row_q      <= 4'd0;
      row_sel_q  <= 16'h0001;
      col_head_q <= 16'h0000;
      col_body_q <= 16'h0000;
      col_food_q <= 16'h0000;
      front_q    <= 1'b0;
    end else begin
      front_q <= front_d;
      if (div_wrap) begin
        div_q      <= '0;
        row_q      <= row_q + 4'd1;
        row_sel_q  <= {row_sel_q[14:0], row_sel_q[15]};
        // front_d so the swapped-in frame is shown from row 0 on the swap edge.
        col_head_q <= head_q[front_d][row_q + 4'd1];
        col_body_q <= body_q[front_d][row_q + 4'd1];
        col_food_q <= food_q[front_d][row_q + 4'd1];
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

  // Back-buffer writes: row clear, segment bits, food bit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 16; r++) begin
          head_q[b][r] <= 16'h0000;
          body_q[b][r] <= 16'h0000;
          food_q[b][r] <= 16'h0000;
        end
      end
    end else begin
      if (clr_row) begin
        head_q[back][cnt_q[3:0]] <= 16'h0000;
        body_q[back][cnt_q[3:0]] <= 16'h0000;
        food_q[back][cnt_q[3:0]] <= 16'h0000;
      end
      if (set_head) head_q[back][bus.Loc_Data[7:4]][bus.Loc_Data[3:0]] <= 1'b1;
      if (set_body) body_q[back][bus.Loc_Data[7:4]][bus.Loc_Data[3:0]] <= 1'b1;
      if (set_food) food_q[back][fd_q[7:4]][fd_q[3:0]] <= 1'b1;
    end
  end

  assign bus.Loc_Idx    = idx_q;
  assign bus.Busy       = busy_q;
  assign bus.Frame_Done = done_q;
  assign bus.Row_Sel    = row_sel_q;
  assign bus.Col_Head   = col_head_q;
  assign bus.Col_Body   = col_body_q;
  assign bus.Col_Food   = col_food_q;

endmodule

// File: tb/tb_snake_matrix_renderer.sv
// Randomized self-checking bench for snake_matrix_renderer with a frame-level model.
module tb_snake_matrix_renderer;

  localparam int unsigned ScanDiv = 4;

  logic Clk;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  logic [7:0]  loc_mem [16];
  logic [15:0] exp_head [16];
  logic [15:0] exp_body [16];
  logic [15:0] exp_food [16];

  snake_matrix_renderer_if bus ();

  snake_matrix_renderer #(.SCAN_DIV(ScanDiv)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Location RAM of the core: one-cycle read latency.
  always @(posedge Clk) bus.Loc_Data <= loc_mem[bus.Loc_Idx];

  always @(negedge Clk) if (bus.Frame_Done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected picture: every rendered segment and the food set their plane bits.
  task automatic build_model(input int len, input logic [7:0] fd);
    logic [7:0] c;
    for (int r = 0; r < 16; r++) begin
      exp_head[r] = '0;
      exp_body[r] = '0;
      exp_food[r] = '0;
    end
    for (int i = 0; i <= len; i++) begin
      c = loc_mem[i];
      if (i == 0) exp_head[c[7:4]][c[3:0]] = 1'b1;
      else exp_body[c[7:4]][c[3:0]] = 1'b1;
    end
    exp_food[fd[7:4]][fd[3:0]] = 1'b1;
  endtask

  task automatic pulse_req();
    @(negedge Clk) bus.Update_Req = 1'b1;
    @(negedge Clk) bus.Update_Req = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (bus.Frame_Done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_frame_done_seen"}, 32'(seen), 32'd1);
  endtask

  // Called on the Frame_Done cycle; walks rows 0..15 of the fresh frame.
  task automatic check_frame(input string tag);
    logic [15:0] one;
    for (int r = 0; r < 16; r++) begin
      one = 16'h0001 << r;
      check($sformatf("%s_rowsel_r%0d", tag, r), 32'(bus.Row_Sel), 32'(one));
      check($sformatf("%s_head_r%0d", tag, r), 32'(bus.Col_Head), 32'(exp_head[r]));
      check($sformatf("%s_body_r%0d", tag, r), 32'(bus.Col_Body), 32'(exp_body[r]));
      check($sformatf("%s_food_r%0d", tag, r), 32'(bus.Col_Food), 32'(exp_food[r]));
      if (r < 15) repeat (ScanDiv) @(negedge Clk);
    end
  endtask

  task automatic run_frame(input string tag, input int len, input logic [7:0] fd);
    bus.Length = 4'(len);
    bus.Food   = fd;
    build_model(len, fd);
    pulse_req();
    wait_frame(tag);
    check_frame(tag);
  endtask

  initial begin
    int base;
    int len;
    logic [7:0] fd;
    Reset          = 1'b1;
    bus.Update_Req = 1'b0;
    bus.Length     = '0;
    bus.Food       = '0;
    for (int i = 0; i < 16; i++) loc_mem[i] = '0;

    // T1: reset values
    repeat (3) @(negedge Clk);
    check("t1_rowsel", 32'(bus.Row_Sel), 32'h0001);
    check("t1_cols", 32'(bus.Col_Head | bus.Col_Body | bus.Col_Food), 32'h0);
    check("t1_busy", 32'(bus.Busy), 32'h0);
    check("t1_locidx", 32'(bus.Loc_Idx), 32'h0);
    check("t1_done", 32'(bus.Frame_Done), 32'h0);
    Reset = 1'b0;

    // T2: initial two-cell snake with food at the origin
    loc_mem[0] = 8'h7D;
    loc_mem[1] = 8'h7C;
    base = done_cnt;
    run_frame("t2", 1, 8'h00);
    check("t2_done_count", 32'(done_cnt - base), 32'd1);

    // T3: full length, index stepping and busy release
    for (int i = 0; i < 16; i++) loc_mem[i] = 8'($urandom);
    fd = 8'($urandom);
    bus.Length = 4'd15;
    bus.Food   = fd;
    build_model(15, fd);
    pulse_req();
    repeat (16) @(negedge Clk);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t3_locidx_%0d", k), 32'(bus.Loc_Idx), 32'(k));
      check($sformatf("t3_busy_%0d", k), 32'(bus.Busy), 32'd1);
      @(negedge Clk);
    end
    wait_frame("t3");
    check("t3_busy_low", 32'(bus.Busy), 32'd0);
    check_frame("t3");

    // T4: head/body self-overlap and body/food overlap
    loc_mem[0] = 8'h33;
    loc_mem[1] = 8'h34;
    loc_mem[2] = 8'h33;
    run_frame("t4", 2, 8'h34);
    @(negedge Clk);

    // Random frames
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) loc_mem[i] = 8'($urandom);
      run_frame($sformatf("rnd%0d", n), int'($urandom_range(0, 15)), 8'($urandom));
      @(negedge Clk);
    end

    // T5: three requests during CLEAR merge into one follow-up build
    for (int i = 0; i < 16; i++) loc_mem[i] = 8'($urandom);
    base = done_cnt;
    len  = int'($urandom_range(0, 15));
    fd   = 8'($urandom);
    bus.Length = 4'(len);
    bus.Food   = fd;
    build_model(len, fd);
    pulse_req();
    len = int'($urandom_range(0, 15));
    fd  = 8'($urandom);
    bus.Length = 4'(len);
    bus.Food   = fd;
    repeat (3) pulse_req();
    wait_frame("t5a");
    check_frame("t5a");
    build_model(len, fd);
    wait_frame("t5b");
    check_frame("t5b");
    repeat (140) @(negedge Clk);
    check("t5_done_count", 32'(done_cnt - base), 32'd2);

    // T6: reset in the middle of LOAD
    for (int i = 0; i < 16; i++) loc_mem[i] = 8'($urandom);
    bus.Length = 4'd10;
    bus.Food   = 8'($urandom);
    pulse_req();
    repeat (21) @(negedge Clk);
    check("t6_idx_before", 32'(bus.Loc_Idx), 32'd5);
    base = done_cnt;
    Reset = 1'b1;
    #1;
    check("t6_rowsel", 32'(bus.Row_Sel), 32'h0001);
    check("t6_cols", 32'(bus.Col_Head | bus.Col_Body | bus.Col_Food), 32'h0);
    check("t6_busy", 32'(bus.Busy), 32'h0);
    check("t6_locidx", 32'(bus.Loc_Idx), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int r = 0; r < 18; r++) begin
      repeat (ScanDiv) @(negedge Clk);
      check($sformatf("t6_blank_%0d", r),
            32'(bus.Col_Head | bus.Col_Body | bus.Col_Food), 32'h0);
    end
    repeat (60) @(negedge Clk);
    check("t6_no_done", 32'(done_cnt - base), 32'd0);
    for (int i = 0; i < 16; i++) loc_mem[i] = 8'($urandom);
    run_frame("t6_fresh", int'($urandom_range(0, 15)), 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
